// File: rtl/i2s_receiver.sv
// I2S slave receiver: resynchronises external SCLK/LRCLK/SDATA into clk, deserialises one
// stereo frame and presents it as {left, right} on a valid/ready stream.
// Latency: LRCLK 1->0 sample edge at the pin to m_valid = SYNC_STAGES+2 clk.
// Backpressure: one-deep output register; a frame completing while m_valid is still held and
// not being accepted is dropped and sets the sticky overflow flag.
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   en                   receiver enable; 0 forces SYNC_WAIT and clears the shift registers
//   sclk, lrclk, sdata   asynchronous I2S pins (data sampled on SCLK rising edge)
//   m_data/m_valid/m_ready  output stream, left channel in the upper half
//   overflow             sticky frame-dropped flag, cleared only by rst
// Optional: define I2S_RX_STATS_EN to add frame_cnt (accepted, wrapping) and drop_cnt
// (dropped, saturating) outputs.
module i2s_receiver #(
    parameter int DATA_W      = 24,
    parameter int DATA_DELAY  = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  sclk,
    input  logic                  lrclk,
    input  logic                  sdata,
    output logic [2*DATA_W-1:0]   m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  overflow
`ifdef I2S_RX_STATS_EN
    ,
    output logic [15:0]           frame_cnt,
    output logic [15:0]           drop_cnt
`endif
);

    typedef enum logic [1:0] {SYNC_WAIT, LEFT, RIGHT} state_t;

    // Slot bit k carries data when DLO <= k < DHI; it lands at shift position BASE - k.
    localparam logic [6:0] DLO  = 7'(DATA_DELAY);
    localparam logic [6:0] DHI  = 7'(DATA_DELAY + DATA_W);
    localparam logic [6:0] BASE = 7'(DATA_W - 1 + DATA_DELAY);

    logic [SYNC_STAGES-1:0] sclk_sync_q,  sclk_sync_d;
    logic [SYNC_STAGES-1:0] lrclk_sync_q, lrclk_sync_d;
    logic [SYNC_STAGES-1:0] sdata_sync_q, sdata_sync_d;
    logic                   sclk_prev_q,  sclk_prev_d;
    logic                   bit_stb_q,    bit_stb_d;
    logic                   lr_smp_q,     lr_smp_d;
    logic                   sd_smp_q,     sd_smp_d;
    logic                   lrclk_prev_q, lrclk_prev_d;
    logic [5:0]             bit_idx_q,    bit_idx_d;
    logic [DATA_W-1:0]      left_sh_q,    left_sh_d;
    logic [DATA_W-1:0]      right_sh_q,   right_sh_d;
    state_t                 state_q,      state_d;
    logic [2*DATA_W-1:0]    m_data_q,     m_data_d;
    logic                   m_valid_q,    m_valid_d;
    logic                   overflow_q,   overflow_d;
`ifdef I2S_RX_STATS_EN
    logic [15:0]            frame_cnt_q,  frame_cnt_d;
    logic [15:0]            drop_cnt_q,   drop_cnt_d;
`endif

    logic       lr_changed;
    logic [5:0] slot_idx;
    logic       in_data;
    logic [6:0] bit_pos;
    logic       frame_done;

    always_comb begin
        // Synchronisers: all three pins share one depth so they stay aligned.
        sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0],  sclk};
        lrclk_sync_d = {lrclk_sync_q[SYNC_STAGES-2:0], lrclk};
        sdata_sync_d = {sdata_sync_q[SYNC_STAGES-2:0], sdata};
        sclk_prev_d  = sclk_sync_q[SYNC_STAGES-1];
        // The strobe is registered together with the lrclk/sdata samples so they line up.
        bit_stb_d    = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
        lr_smp_d     = lrclk_sync_q[SYNC_STAGES-1];
        sd_smp_d     = sdata_sync_q[SYNC_STAGES-1];

        lr_changed   = bit_stb_q & (lr_smp_q != lrclk_prev_q);
        slot_idx     = lr_changed ? 6'd0 :
                       ((bit_idx_q == 6'd63) ? 6'd63 : bit_idx_q + 6'd1);
        lrclk_prev_d = bit_stb_q ? lr_smp_q : lrclk_prev_q;
        bit_idx_d    = bit_stb_q ? slot_idx : bit_idx_q;
        in_data      = ({1'b0, slot_idx} >= DLO) && ({1'b0, slot_idx} < DHI);
        bit_pos      = BASE - {1'b0, slot_idx};

        // Slot registers are cleared at slot start so a short slot leaves zero LSBs.
        left_sh_d  = left_sh_q;
        right_sh_d = right_sh_q;
        if (!en) begin
            left_sh_d  = '0;
            right_sh_d = '0;
        end else if (bit_stb_q) begin
            if (!lr_smp_q) begin
                if (lr_changed) left_sh_d = '0;
                if (in_data) begin
                    for (int i = 0; i < DATA_W; i++) begin
                        if (bit_pos == 7'(i)) left_sh_d[i] = sd_smp_q;
                    end
                end
            end else begin
                if (lr_changed) right_sh_d = '0;
                if (in_data) begin
                    for (int i = 0; i < DATA_W; i++) begin
                        if (bit_pos == 7'(i)) right_sh_d[i] = sd_smp_q;
                    end
                end
            end
        end

        // Only a 1->0 change opens a frame, so a partial frame after reset/en is skipped.
        state_d = state_q;
        if (!en) begin
            state_d = SYNC_WAIT;
        end else if (lr_changed) begin
            case (state_q)
                SYNC_WAIT: if (!lr_smp_q) state_d = LEFT;
                LEFT:      if (lr_smp_q)  state_d = RIGHT;
                RIGHT:     if (!lr_smp_q) state_d = LEFT;
                default:   state_d = SYNC_WAIT;
            endcase
        end

        // Frame ends when the next left slot begins; shift regs still hold the old frame.
        frame_done = en & lr_changed & ~lr_smp_q & (state_q == RIGHT);

        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        overflow_d = overflow_q;
`ifdef I2S_RX_STATS_EN
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
`endif
        if (frame_done) begin
            if (!m_valid_q || m_ready) begin
                m_data_d  = {left_sh_q, right_sh_q};
                m_valid_d = 1'b1;
`ifdef I2S_RX_STATS_EN
                frame_cnt_d = frame_cnt_q + 16'd1;
`endif
            end else begin
                overflow_d = 1'b1;
`ifdef I2S_RX_STATS_EN
                if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
`endif
            end
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q  <= '0;
            lrclk_sync_q <= '0;
            sdata_sync_q <= '0;
            sclk_prev_q  <= 1'b0;
            bit_stb_q    <= 1'b0;
            lr_smp_q     <= 1'b0;
            sd_smp_q     <= 1'b0;
            lrclk_prev_q <= 1'b0;
            bit_idx_q    <= '0;
            left_sh_q    <= '0;
            right_sh_q   <= '0;
            state_q      <= SYNC_WAIT;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            overflow_q   <= 1'b0;
`ifdef I2S_RX_STATS_EN
            frame_cnt_q  <= '0;
            drop_cnt_q   <= '0;
`endif
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            lrclk_sync_q <= lrclk_sync_d;
            sdata_sync_q <= sdata_sync_d;
            sclk_prev_q  <= sclk_prev_d;
            bit_stb_q    <= bit_stb_d;
            lr_smp_q     <= lr_smp_d;
            sd_smp_q     <= sd_smp_d;
            lrclk_prev_q <= lrclk_prev_d;
            bit_idx_q    <= bit_idx_d;
            left_sh_q    <= left_sh_d;
            right_sh_q   <= right_sh_d;
            state_q      <= state_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            overflow_q   <= overflow_d;
`ifdef I2S_RX_STATS_EN
            frame_cnt_q  <= frame_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
`endif
        end
    end

    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
    assign overflow = overflow_q;
`ifdef I2S_RX_STATS_EN
    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_receiver.sv
module tb_i2s_receiver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, sclk, lrclk, sdata, m_ready;
    logic [47:0] m_data, lj_data;
    logic        m_valid, lj_valid, overflow, lj_overflow;
`ifdef I2S_RX_STATS_EN
    logic [15:0] frame_cnt, drop_cnt, lj_frame_cnt, lj_drop_cnt;
`endif

    // Standard I2S instance and a left-justified instance on the same pins.
    i2s_receiver #(.DATA_W(24), .DATA_DELAY(1), .SYNC_STAGES(2)) u_dut (
        .clk(clk), .rst(rst), .en(en), .sclk(sclk), .lrclk(lrclk), .sdata(sdata),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .overflow(overflow)
`ifdef I2S_RX_STATS_EN
        , .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
`endif
    );
    i2s_receiver #(.DATA_W(24), .DATA_DELAY(0), .SYNC_STAGES(2)) u_lj (
        .clk(clk), .rst(rst), .en(en), .sclk(sclk), .lrclk(lrclk), .sdata(sdata),
        .m_data(lj_data), .m_valid(lj_valid), .m_ready(m_ready), .overflow(lj_overflow)
`ifdef I2S_RX_STATS_EN
        , .frame_cnt(lj_frame_cnt), .drop_cnt(lj_drop_cnt)
`endif
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int valid_cycles = 0;
    logic prev_valid = 1'b0;
    logic [47:0] got_q[$];
    logic [47:0] lj_q[$];
    int rise_q[$];
    int mark_q[$];

    always @(posedge clk) cyc++;

    // Log handshakes, valid-high cycles and valid rising cycles, sampled mid-cycle.
    always @(negedge clk) begin
        if (m_valid) valid_cycles++;
        if (m_valid && m_ready) got_q.push_back(m_data);
        if (m_valid && !prev_valid) rise_q.push_back(cyc);
        prev_valid = m_valid;
        if (lj_valid && m_ready) lj_q.push_back(lj_data);
    end

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic clear_logs();
        @(negedge clk); #1;
        got_q.delete(); lj_q.delete(); rise_q.delete(); mark_q.delete();
        valid_cycles = 0;
        @(negedge clk);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk); #2 m_ready = v;
        @(negedge clk);
    endtask

    // One SCLK period = 8 clk; data/lrclk change on the falling edge.
    task automatic send_bit(input logic lr, input logic d, input bit mark);
        sclk = 1'b0; lrclk = lr; sdata = d;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        if (mark) mark_q.push_back(cyc);
        repeat (4) @(negedge clk);
    endtask

    task automatic send_slot(input logic lr, input logic [23:0] w, input int bits,
                             input int dly, input logic fill);
        logic b;
        for (int k = 0; k < bits; k++) begin
            b = (k >= dly && k < dly + 24) ? w[23 - (k - dly)] : fill;
            send_bit(lr, b, (k == 0) && (lr == 1'b0));
        end
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int bits,
                              input int dly, input logic fill);
        send_slot(1'b0, l, bits, dly, fill);
        send_slot(1'b1, r, bits, dly, fill);
    endtask

    task automatic preamble();
        repeat (4) send_bit(1'b1, 1'b0, 1'b0);
    endtask

    task automatic flush();
        send_slot(1'b0, 24'h0, 8, 1, 1'b0);
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b expected 0", m_valid); end
        vectors++; if (m_data !== 48'h0) begin miscompares++; $display("FAIL rst_data: got %h expected 0", m_data); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL rst_ovf: got %b expected 0", overflow); end
        vectors++; if (lj_valid !== 1'b0 || lj_overflow !== 1'b0) begin miscompares++; $display("FAIL rst_lj: got valid=%b ovf=%b expected 0 0", lj_valid, lj_overflow); end
`ifdef I2S_RX_STATS_EN
        vectors++; if (frame_cnt !== 16'h0 || drop_cnt !== 16'h0) begin miscompares++; $display("FAIL rst_cnt: got %h %h expected 0 0", frame_cnt, drop_cnt); end
`endif
    endtask

    task automatic test_i2s_frames();
        do_reset(); clear_logs();
        preamble();
        repeat (3) send_frame(24'hA5A5A5, 24'h5A5A5A, 32, 1, 1'b0);
        flush();
        vectors++; if (got_q.size() != 3) begin miscompares++; $display("FAIL t1_count: got %0d expected 3", got_q.size()); end
        foreach (got_q[i]) begin
            vectors++; if (got_q[i] !== 48'hA5A5A55A5A5A) begin miscompares++; $display("FAIL t1_data%0d: got %h expected a5a5a55a5a5a", i, got_q[i]); end
        end
        vectors++; if (valid_cycles != 3) begin miscompares++; $display("FAIL t1_valid_cycles: got %0d expected 3", valid_cycles); end
        for (int i = 0; i < rise_q.size() && i + 1 < mark_q.size(); i++) begin
            vectors++; if (rise_q[i] - mark_q[i+1] != 4) begin miscompares++; $display("FAIL t1_latency%0d: got %0d expected 4", i, rise_q[i] - mark_q[i+1]); end
        end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL t1_ovf: got %b expected 0", overflow); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset(); clear_logs();
        preamble();
        send_slot(1'b0, 24'h777777, 32, 1, 1'b0);
        for (int k = 0; k < 16; k++) send_bit(1'b1, 1'b1, 1'b0);
        do_reset(); clear_logs();
        for (int k = 16; k < 32; k++) send_bit(1'b1, 1'b1, 1'b0);
        send_frame(24'h123456, 24'hFEDCBA, 32, 1, 1'b0);
        flush();
        vectors++; if (got_q.size() != 1) begin miscompares++; $display("FAIL t2_count: got %0d expected 1", got_q.size()); end
        if (got_q.size() > 0) begin
            vectors++; if (got_q[0] !== 48'h123456FEDCBA) begin miscompares++; $display("FAIL t2_data: got %h expected 123456fedcba", got_q[0]); end
        end
    endtask

    task automatic test_overflow();
        do_reset(); clear_logs();
        set_ready(1'b0);
        preamble();
        send_frame(24'h111111, 24'h222222, 32, 1, 1'b0);
        send_frame(24'h333333, 24'h444444, 32, 1, 1'b0);
        send_frame(24'h555555, 24'h666666, 32, 1, 1'b0);
        flush();
        vectors++; if (m_valid !== 1'b1) begin miscompares++; $display("FAIL t3_held_valid: got %b expected 1", m_valid); end
        vectors++; if (m_data !== 48'h111111222222) begin miscompares++; $display("FAIL t3_held_data: got %h expected 111111222222", m_data); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL t3_ovf: got %b expected 1", overflow); end
`ifdef I2S_RX_STATS_EN
        vectors++; if (drop_cnt !== 16'd2) begin miscompares++; $display("FAIL t3_drop_cnt: got %0d expected 2", drop_cnt); end
        vectors++; if (frame_cnt !== 16'd1) begin miscompares++; $display("FAIL t3_frame_cnt: got %0d expected 1", frame_cnt); end
`endif
        set_ready(1'b1);
        @(negedge clk);
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL t3_drain_valid: got %b expected 0", m_valid); end
        vectors++; if (m_data !== 48'h111111222222) begin miscompares++; $display("FAIL t3_drain_data: got %h expected 111111222222", m_data); end
        vectors++; if (got_q.size() != 1) begin miscompares++; $display("FAIL t3_drain_count: got %0d expected 1", got_q.size()); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL t3_ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_left_justified();
        do_reset(); clear_logs();
        preamble();
        send_frame(24'h800001, 24'h000001, 32, 0, 1'b0);
        flush();
        vectors++; if (lj_q.size() != 1) begin miscompares++; $display("FAIL t4_count: got %0d expected 1", lj_q.size()); end
        if (lj_q.size() > 0) begin
            vectors++; if (lj_q[0] !== 48'h800001000001) begin miscompares++; $display("FAIL t4_data: got %h expected 800001000001", lj_q[0]); end
        end
`ifdef I2S_RX_STATS_EN
        vectors++; if (lj_frame_cnt !== 16'd1 || lj_drop_cnt !== 16'd0) begin miscompares++; $display("FAIL t4_cnt: got %0d %0d expected 1 0", lj_frame_cnt, lj_drop_cnt); end
`endif
    endtask

    task automatic test_slot_length();
        do_reset(); clear_logs();
        preamble();
        send_frame(24'hFFFFFF, 24'h000003, 24, 1, 1'b0);
        send_frame(24'h123456, 24'h00FF00, 32, 1, 1'b1);
        flush();
        vectors++; if (got_q.size() != 2) begin miscompares++; $display("FAIL t5_count: got %0d expected 2", got_q.size()); end
        if (got_q.size() > 1) begin
            vectors++; if (got_q[0] !== 48'hFFFFFE000002) begin miscompares++; $display("FAIL t5_short: got %h expected fffffe000002", got_q[0]); end
            vectors++; if (got_q[1] !== 48'h12345600FF00) begin miscompares++; $display("FAIL t5_long: got %h expected 12345600ff00", got_q[1]); end
        end
    endtask

    task automatic test_enable();
        logic [23:0] w;
        do_reset(); clear_logs();
        preamble();
        w = 24'h9ABCDE;
        for (int k = 0; k < 32; k++) begin
            if (k == 16) en = 1'b0;
            send_bit(1'b0, (k >= 1 && k < 25) ? w[24 - k] : 1'b0, k == 0);
        end
        for (int k = 0; k < 32; k++) begin
            if (k == 16) en = 1'b1;
            send_bit(1'b1, 1'b1, 1'b0);
        end
        send_frame(24'h0F0F0F, 24'hC3C3C3, 32, 1, 1'b0);
        flush();
        vectors++; if (got_q.size() != 1) begin miscompares++; $display("FAIL t6_count: got %0d expected 1", got_q.size()); end
        if (got_q.size() > 0) begin
            vectors++; if (got_q[0] !== 48'h0F0F0FC3C3C3) begin miscompares++; $display("FAIL t6_data: got %h expected 0f0f0fc3c3c3", got_q[0]); end
        end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL t6_ovf: got %b expected 0", overflow); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; sclk = 1'b0; lrclk = 1'b1; sdata = 1'b0; m_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_i2s_frames();
        test_reset_mid_frame();
        test_overflow();
        test_left_justified();
        test_slot_length();
        test_enable();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
